// File: rtl/riscv_run_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_run_checker_pkg
// Purpose : Shared constants for the end-of-program run checker: FSM state
//           encodings and counter widths.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package riscv_run_checker_pkg;

  localparam int c_STATE_W = 3;

  localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
  localparam logic [c_STATE_W-1:0] c_ST_RUN   = 3'd1;
  localparam logic [c_STATE_W-1:0] c_ST_HOLD  = 3'd2;
  localparam logic [c_STATE_W-1:0] c_ST_CHECK = 3'd3;
  localparam logic [c_STATE_W-1:0] c_ST_PASS  = 3'd4;
  localparam logic [c_STATE_W-1:0] c_ST_FAIL  = 3'd5;

  localparam int c_CYCLE_W = 32;
  localparam int c_STORE_W = 16;

endpackage
`default_nettype wire

// File: rtl/riscv_run_checker_entry.sv
`default_nettype none
// ============================================================================
// Module  : riscv_chk_entry
// Purpose : One expectation-table entry. Holds the expected word address and
//           data, and tracks whether the entry is armed, whether a store to its
//           address has been seen, and whether the most recent such store
//           carried the expected data.
// Ports   : i_CLK, i_Reset        clock / synchronous active-high reset
//           i_load, i_load_addr,
//           i_load_data           write this entry (caller gates to IDLE)
//           i_store, i_store_addr,
//           i_store_data          qualified store snoop (word address)
//           o_armed               entry holds a valid expectation
//           o_hit                 seen & match
// Rev     : 1.0  initial release
// ============================================================================
module riscv_chk_entry
  import riscv_run_checker_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8
) (
  input  logic              i_CLK,
  input  logic              i_Reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [XLEN-1:0]   i_load_data,
  input  logic              i_store,
  input  logic [ADDR_W-1:0] i_store_addr,
  input  logic [XLEN-1:0]   i_store_data,
  output logic              o_armed,
  output logic              o_hit
);

  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_data;
  logic              r_armed;
  logic              r_seen;
  logic              r_match;
  logic              w_addr_hit;

  assign w_addr_hit = i_store && r_armed && (i_store_addr == r_addr);

  // Table contents are meaningless until armed, so they carry no reset.
  always_ff @(posedge i_CLK) begin
    if (i_load) begin
      r_addr <= i_load_addr;
      r_data <= i_load_data;
    end
  end

  // Every store to the entry's address re-evaluates match, so the last write
  // decides the verdict.
  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      r_armed <= 1'b0;
      r_seen  <= 1'b0;
      r_match <= 1'b0;
    end else begin
      if (i_load) begin
        r_armed <= 1'b1;
      end
      if (w_addr_hit) begin
        r_seen  <= 1'b1;
        r_match <= (i_store_data == r_data);
      end
    end
  end

  assign o_armed = r_armed;
  assign o_hit   = r_seen & r_match;

endmodule
`default_nettype wire

// File: rtl/riscv_run_checker.sv
`default_nettype none
// ============================================================================
// Module  : riscv_run_checker
// Purpose : End-of-program checker for the single-cycle RISC-V core. Snoops
//           PC and store traffic, detects the halt PC, and compares the last
//           store to each expected word address against its expected data.
// Ports   : i_CLK, i_Reset        clock / synchronous active-high reset
//           i_Start               IDLE -> RUN pulse
//           i_PC, i_MemWrite,
//           i_ALUResult,
//           i_WriteData           core snoop (ALUResult = store byte address)
//           i_ExpLoad, i_ExpIdx,
//           i_ExpAddr, i_ExpData  expectation table write (IDLE only)
//           o_Done, o_Pass,
//           o_Timeout             verdict flags
//           o_CycleCount          RUN/HOLD cycles, saturating
//           o_StoreCount          stores seen in RUN/HOLD, saturating
//           o_MatchMask           per-entry seen & match
// Rev     : 1.0  initial release
// ============================================================================
module riscv_run_checker
  import riscv_run_checker_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              ADDR_W      = 8,
  parameter int              NUM_CHECKS  = 4,
  parameter logic [XLEN-1:0] HALT_PC     = 'h48,
  parameter int              HALT_HOLD   = 1,
  parameter int              TIMEOUT_CYC = 1024
) (
  input  logic                          i_CLK,
  input  logic                          i_Reset,
  input  logic                          i_Start,
  input  logic [XLEN-1:0]               i_PC,
  input  logic                          i_MemWrite,
  input  logic [XLEN-1:0]               i_ALUResult,
  input  logic [XLEN-1:0]               i_WriteData,
  input  logic                          i_ExpLoad,
  input  logic [$clog2(NUM_CHECKS)-1:0] i_ExpIdx,
  input  logic [ADDR_W-1:0]             i_ExpAddr,
  input  logic [XLEN-1:0]               i_ExpData,
  output logic                          o_Done,
  output logic                          o_Pass,
  output logic                          o_Timeout,
  output logic [c_CYCLE_W-1:0]          o_CycleCount,
  output logic [c_STORE_W-1:0]          o_StoreCount,
  output logic [NUM_CHECKS-1:0]         o_MatchMask
);

  localparam int c_IDX_W = $clog2(NUM_CHECKS);
  localparam logic [c_CYCLE_W-1:0] c_TIMEOUT_LAST = c_CYCLE_W'(TIMEOUT_CYC - 1);
  // HALT_HOLD must be at least 1: HOLD always lasts one cycle or more.
  localparam logic [c_CYCLE_W-1:0] c_HOLD_LAST    = c_CYCLE_W'(HALT_HOLD - 1);
  localparam logic [c_CYCLE_W-1:0] c_CYC_ONE      = c_CYCLE_W'(1);
  localparam logic [c_STORE_W-1:0] c_ST_ONE       = c_STORE_W'(1);

  logic [c_STATE_W-1:0]  r_state;
  logic [c_STATE_W-1:0]  w_state_nxt;
  logic [c_CYCLE_W-1:0]  r_cycle_cnt;
  logic [c_STORE_W-1:0]  r_store_cnt;
  logic [c_CYCLE_W-1:0]  r_hold_cnt;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_timeout;
  logic                  w_done_nxt;
  logic                  w_pass_nxt;
  logic                  w_timeout_nxt;
  logic                  w_active;
  logic                  w_load_ok;
  logic                  w_store;
  logic [ADDR_W-1:0]     w_store_word;
  logic                  w_halt;
  logic                  w_timeout_hit;
  logic                  w_hold_done;
  logic [NUM_CHECKS-1:0] w_armed;
  logic [NUM_CHECKS-1:0] w_hit;
  logic                  w_pass_all;
  logic                  w_unused_alu_bits;

  assign w_active      = (r_state == c_ST_RUN) || (r_state == c_ST_HOLD);
  assign w_load_ok     = i_ExpLoad && (r_state == c_ST_IDLE);
  assign w_store       = i_MemWrite && w_active;
  assign w_store_word  = i_ALUResult[ADDR_W+1:2];
  assign w_halt        = (i_PC == HALT_PC);
  assign w_timeout_hit = (r_cycle_cnt == c_TIMEOUT_LAST);
  assign w_hold_done   = (r_hold_cnt >= c_HOLD_LAST);
  // Unarmed entries are vacuously satisfied, so an empty table passes.
  assign w_pass_all    = &(~w_armed | w_hit);

  // Byte-lane and upper address bits do not take part in the word compare.
  assign w_unused_alu_bits = ^{i_ALUResult[XLEN-1:ADDR_W+2], i_ALUResult[1:0]};

  generate
    for (genvar k = 0; k < NUM_CHECKS; k++) begin : g_entry
      riscv_chk_entry #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
      ) u_entry (
        .i_CLK        (i_CLK),
        .i_Reset      (i_Reset),
        .i_load       (w_load_ok && (i_ExpIdx == c_IDX_W'(k))),
        .i_load_addr  (i_ExpAddr),
        .i_load_data  (i_ExpData),
        .i_store      (w_store),
        .i_store_addr (w_store_word),
        .i_store_data (i_WriteData),
        .o_armed      (w_armed[k]),
        .o_hit        (w_hit[k])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state. Halt is tested before timeout so a halt on the last allowed
  // cycle still gets a proper verdict.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (i_Start) w_state_nxt = c_ST_RUN;
      c_ST_RUN: begin
        if (w_halt)             w_state_nxt = c_ST_HOLD;
        else if (w_timeout_hit) w_state_nxt = c_ST_FAIL;
      end
      c_ST_HOLD:  if (w_hold_done) w_state_nxt = c_ST_CHECK;
      c_ST_CHECK: w_state_nxt = w_pass_all ? c_ST_PASS : c_ST_FAIL;
      c_ST_PASS:  w_state_nxt = c_ST_PASS;
      c_ST_FAIL:  w_state_nxt = c_ST_FAIL;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Verdict flags follow the state being entered; PASS/FAIL are terminal so
  // the flags hold until reset.
  always_comb begin
    w_done_nxt    = (w_state_nxt == c_ST_PASS) || (w_state_nxt == c_ST_FAIL);
    w_pass_nxt    = (w_state_nxt == c_ST_PASS);
    w_timeout_nxt = r_timeout ||
                    ((r_state == c_ST_RUN) && (w_state_nxt == c_ST_FAIL));
  end

  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Saturating counters and the HOLD-phase dwell counter.
  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      r_cycle_cnt <= '0;
      r_store_cnt <= '0;
      r_hold_cnt  <= '0;
    end else begin
      if (w_active && (r_cycle_cnt != '1)) begin
        r_cycle_cnt <= r_cycle_cnt + c_CYC_ONE;
      end
      if (w_store && (r_store_cnt != '1)) begin
        r_store_cnt <= r_store_cnt + c_ST_ONE;
      end
      if (r_state == c_ST_HOLD) begin
        r_hold_cnt <= r_hold_cnt + c_CYC_ONE;
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  assign o_Done       = r_done;
  assign o_Pass       = r_pass;
  assign o_Timeout    = r_timeout;
  assign o_CycleCount = r_cycle_cnt;
  assign o_StoreCount = r_store_cnt;
  assign o_MatchMask  = w_hit;

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_run_checker
// Purpose : Self-checking bench for riscv_run_checker. A program-level model
//           (table of expectations plus a queue of recorded stores) predicts
//           every output each cycle; directed scenarios pin the model with
//           literal values, then randomized programs exercise the rest.
// Rev     : 1.0  initial release
// ============================================================================
module tb_riscv_run_checker;

  localparam logic [31:0] HALT = 32'h48;
  localparam int          TO   = 16;
  localparam int          HH   = 1;

  logic        clk = 1'b0;
  logic        rst, start, mem_we, exp_load;
  logic [31:0] pc, alu, wdata, exp_dat;
  logic [1:0]  exp_idx;
  logic [7:0]  exp_addr;
  logic        done, pass, tout;
  logic [31:0] cyc;
  logic [15:0] stc;
  logic [3:0]  mask;

  always #5 clk = ~clk;

  riscv_run_checker #(
    .XLEN(32), .ADDR_W(8), .NUM_CHECKS(4), .HALT_PC(HALT),
    .HALT_HOLD(HH), .TIMEOUT_CYC(TO)
  ) dut (
    .i_CLK(clk), .i_Reset(rst), .i_Start(start), .i_PC(pc),
    .i_MemWrite(mem_we), .i_ALUResult(alu), .i_WriteData(wdata),
    .i_ExpLoad(exp_load), .i_ExpIdx(exp_idx), .i_ExpAddr(exp_addr),
    .i_ExpData(exp_dat), .o_Done(done), .o_Pass(pass), .o_Timeout(tout),
    .o_CycleCount(cyc), .o_StoreCount(stc), .o_MatchMask(mask)
  );

  // ---------------- model ----------------
  typedef struct { logic [7:0] a; logic [31:0] d; } st_t;
  bit          m_armed [4];
  logic [7:0]  m_addr  [4];
  logic [31:0] m_data  [4];
  st_t         sq[$];

  logic        e_done, e_pass, e_tout;
  logic [31:0] e_cyc;
  logic [15:0] e_st;
  logic [3:0]  e_mask;
  bit          chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // program description, one slot per RUN-relative cycle
  logic [31:0] p_pc[32], p_alu[32], p_wd[32], p_jdata[32];
  bit          p_we[32], p_jload[32], p_jstart[32];
  logic [1:0]  p_jidx[32];
  logic [7:0]  p_jaddr[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entry k is good when its most recent recorded store carried the data.
  function automatic logic [3:0] model_mask();
    logic [3:0] m = 4'b0;
    for (int k = 0; k < 4; k++) begin
      if (m_armed[k]) begin
        for (int i = sq.size() - 1; i >= 0; i--) begin
          if (sq[i].a == m_addr[k]) begin
            m[k] = (sq[i].d == m_data[k]);
            break;
          end
        end
      end
    end
    return m;
  endfunction

  function automatic logic [3:0] armed_vec();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_armed[k];
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("done",    32'(done), 32'(e_done));
      check("pass",    32'(pass), 32'(e_pass));
      check("timeout", 32'(tout), 32'(e_tout));
      check("cycles",  cyc,       e_cyc);
      check("stores",  32'(stc),  32'(e_st));
      check("mask",    32'(mask), 32'(e_mask));
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic idle_inputs();
    start = 0; exp_load = 0; mem_we = 0; pc = 32'h0; alu = 0; wdata = 0;
    exp_idx = 0; exp_addr = 0; exp_dat = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 4; k++) m_armed[k] = 0;
    sq.delete();
    e_done = 0; e_pass = 0; e_tout = 0; e_cyc = 0; e_st = 0; e_mask = 0;
    chk_en = 1;
  endtask

  task automatic load(input int idx, input logic [7:0] a, input logic [31:0] d, input bit st);
    exp_load = 1; exp_idx = 2'(idx); exp_addr = a; exp_dat = d; start = st;
    @(posedge clk); #1;
    exp_load = 0; start = 0;
    m_armed[idx] = 1; m_addr[idx] = a; m_data[idx] = d;
  endtask

  task automatic go();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic clear_prog();
    for (int j = 0; j < 32; j++) begin
      p_pc[j] = 32'h100 + 32'(4 * j); p_we[j] = 0; p_alu[j] = 0; p_wd[j] = 0;
      p_jload[j] = 0; p_jstart[j] = 0; p_jidx[j] = 0; p_jaddr[j] = 0; p_jdata[j] = 0;
    end
  endtask

  task automatic set_store(input int j, input logic [31:0] a, input logic [31:0] d);
    p_we[j] = 1; p_alu[j] = a; p_wd[j] = d;
  endtask

  // Drives the program from the first RUN cycle and predicts outputs from
  // the halt position: RUN cycles 0..h, HALT_HOLD hold cycles, one check.
  task automatic run_program();
    int h = -1;
    int last;
    for (int j = 0; j < TO; j++) begin
      if (p_pc[j] == HALT) begin h = j; break; end
    end
    last = (h >= 0) ? h + HH : TO - 1;
    for (int j = 0; j < last + 3; j++) begin
      pc = p_pc[j]; mem_we = p_we[j]; alu = p_alu[j]; wdata = p_wd[j];
      exp_load = p_jload[j]; exp_idx = p_jidx[j]; exp_addr = p_jaddr[j];
      exp_dat = p_jdata[j]; start = p_jstart[j];
      @(posedge clk); #1;
      if (p_we[j] && j <= last) sq.push_back('{a: p_alu[j][9:2], d: p_wd[j]});
      e_cyc  = 32'((j + 1 < last + 1) ? j + 1 : last + 1);
      e_st   = (sq.size() > 65535) ? 16'hffff : 16'(sq.size());
      e_mask = model_mask();
      if (h >= 0) begin
        e_done = (j >= last + 1); e_tout = 0;
      end else begin
        e_done = (j >= TO - 1);   e_tout = e_done;
      end
      e_pass = e_done && !e_tout && ((e_mask | ~armed_vec()) == 4'hF);
    end
    idle_inputs();
  endtask

  task automatic std_table();
    do_reset();
    load(0, 8'h18, 32'd7, 0);
    load(1, 8'h17, 32'd25, 0);
    go();
    clear_prog();
  endtask

  task automatic random_run();
    int nl = $urandom_range(0, 6);
    int ht = $urandom_range(0, 19);
    bit started = 0;
    logic [31:0] tmp;
    do_reset();
    for (int i = 0; i < nl; i++) begin
      bit st = (i == nl - 1) && ($urandom_range(0, 1) == 1);
      load($urandom_range(0, 3), 8'h10 + 8'($urandom_range(0, 5)), 32'($urandom_range(0, 3)), st);
      if (st) started = 1;
    end
    if (!started) go();
    clear_prog();
    for (int j = 0; j < 32; j++) begin
      tmp = $urandom;
      if (tmp == HALT) tmp = tmp ^ 32'h1;
      p_pc[j] = (j == ht) ? HALT : tmp;
      p_we[j] = ($urandom_range(0, 1) == 1);
      tmp = $urandom;
      tmp[9:2] = 8'h10 + 8'($urandom_range(0, 7));
      p_alu[j]   = tmp;
      p_wd[j]    = 32'($urandom_range(0, 3));
      p_jload[j] = ($urandom_range(0, 3) == 0);
      p_jidx[j]  = 2'($urandom_range(0, 3));
      p_jaddr[j] = 8'h10 + 8'($urandom_range(0, 5));
      p_jdata[j] = 32'($urandom_range(0, 3));
      p_jstart[j] = ($urandom_range(0, 1) == 1);
    end
    run_program();
  endtask

  // ---------------- sequence ----------------
  initial begin
    idle_inputs();
    rst = 1;

    // 1: both stores correct; junk loads and starts during RUN are ignored
    std_table();
    check("rst_cycles", cyc, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    set_store(0, 32'h60, 32'd7);
    set_store(1, 32'h5C, 32'd25);
    p_pc[2] = HALT;
    for (int j = 0; j < 4; j++) begin
      p_jload[j] = 1; p_jidx[j] = 2'd0; p_jaddr[j] = 8'h18; p_jdata[j] = 32'd9; p_jstart[j] = 1;
    end
    run_program();
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_mask", 32'(mask), 32'h3);
    check("t1_cycles", cyc, 32'd4);
    check("t1_stores", 32'(stc), 32'd2);

    // 2: wrong data at 0x60
    std_table();
    set_store(0, 32'h60, 32'd8);
    set_store(1, 32'h5C, 32'd25);
    p_pc[2] = HALT;
    run_program();
    check("t2_done", 32'(done), 32'd1);
    check("t2_pass", 32'(pass), 32'd0);
    check("t2_mask", 32'(mask), 32'h2);
    check("t2_timeout", 32'(tout), 32'd0);

    // 3a: wrong then right -> last write wins
    std_table();
    set_store(0, 32'h60, 32'd8);
    set_store(1, 32'h60, 32'd7);
    set_store(2, 32'h5C, 32'd25);
    p_pc[3] = HALT;
    run_program();
    check("t3a_pass", 32'(pass), 32'd1);
    check("t3a_mask", 32'(mask), 32'h3);
    check("t3a_cycles", cyc, 32'd5);

    // 3b: right then wrong
    std_table();
    set_store(0, 32'h60, 32'd7);
    set_store(1, 32'h60, 32'd8);
    set_store(2, 32'h5C, 32'd25);
    p_pc[3] = HALT;
    run_program();
    check("t3b_pass", 32'(pass), 32'd0);
    check("t3b_mask", 32'(mask), 32'h2);

    // 4: never halts; load and start in the same cycle
    do_reset();
    load(0, 8'h18, 32'd7, 1);
    clear_prog();
    set_store(0, 32'h60, 32'd7);
    run_program();
    check("t4_done", 32'(done), 32'd1);
    check("t4_pass", 32'(pass), 32'd0);
    check("t4_timeout", 32'(tout), 32'd1);
    check("t4_cycles", cyc, 32'd16);
    check("t4_mask", 32'(mask), 32'h1);

    // 5a: store in the halt-detect cycle is recorded
    std_table();
    set_store(0, 32'h60, 32'd7);
    set_store(1, 32'h5C, 32'd25);
    p_pc[1] = HALT;
    run_program();
    check("t5a_pass", 32'(pass), 32'd1);
    check("t5a_stores", 32'(stc), 32'd2);
    check("t5a_cycles", cyc, 32'd3);

    // 5b: halt on the last cycle before timeout wins
    std_table();
    set_store(0, 32'h60, 32'd7);
    set_store(1, 32'h5C, 32'd25);
    p_pc[15] = HALT;
    run_program();
    check("t5b_timeout", 32'(tout), 32'd0);
    check("t5b_pass", 32'(pass), 32'd1);
    check("t5b_cycles", cyc, 32'd17);

    // empty table passes
    do_reset();
    go();
    clear_prog();
    p_pc[0] = HALT;
    set_store(0, 32'h60, 32'd3);
    run_program();
    check("empty_pass", 32'(pass), 32'd1);
    check("empty_mask", 32'(mask), 32'h0);

    // 6: reset mid-RUN aborts and clears the table arming
    do_reset();
    load(0, 8'h18, 32'd7, 0);
    load(1, 8'h17, 32'd25, 0);
    go();
    chk_en = 0;
    pc = 32'h100; mem_we = 1; alu = 32'h60; wdata = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    check("t6_cycles", cyc, 32'd0);
    check("t6_stores", 32'(stc), 32'd0);
    check("t6_mask", 32'(mask), 32'h0);
    check("t6_done", 32'(done), 32'd0);
    load(0, 8'h18, 32'd7, 0);
    go();
    clear_prog();
    set_store(0, 32'h60, 32'd7);
    p_pc[1] = HALT;
    run_program();
    check("t6_pass", 32'(pass), 32'd1);

    for (int r = 0; r < 40; r++) random_run();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
